// File: rtl/mdu_rhl.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle.
module mdu_rhl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        RHLSel,
  output logic        busy,
  output logic [31:0] RHLOut
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] work;
  logic [31:0] opb;
  logic        s_a;
  logic        s_b;
  logic        dz;

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        is_mthi;
  logic        is_mtlo;
  logic        is_mul;
  logic        is_div;
  logic        last;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_s;

  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & A[31];
  assign b_neg     = signed_op & B[31];
  assign a_abs     = a_neg ? -A : A;
  assign b_abs     = b_neg ? -B : B;

  assign is_mthi = start && (op == 3'b100);
  assign is_mtlo = start && (op == 3'b101);
  assign is_mul  = start && (op[2:1] == 2'b00);
  assign is_div  = start && (op[2:1] == 2'b01);
  assign last    = (count == 5'(ITER - 1));

  // work = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, work[63:32]}
                  + (work[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, work[31:1]};
  assign prod_s   = (s_a ^ s_b) ? -mul_next : mul_next;

  // work = {partial remainder, dividend/quotient}
  assign div_sh   = {work[63:32], work[31]};
  assign div_ge   = (div_sh >= {1'b0, opb});
  assign div_sub  = div_sh[31:0] - opb;
  assign div_rem  = div_ge ? div_sub : div_sh[31:0];
  assign div_next = {div_rem, work[30:0], div_ge};
  assign quo_s    = dz ? 32'hFFFF_FFFF
                  : (s_a ^ s_b) ? -div_next[31:0]
                  : div_next[31:0];
  assign rem_s    = s_a ? -div_next[63:32] : div_next[63:32];

  assign RHLOut = RHLSel ? hi : lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      work  <= '0;
      opb   <= '0;
      s_a   <= 1'b0;
      s_b   <= 1'b0;
      dz    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_mthi: hi <= A;
            is_mtlo: lo <= A;
            is_mul: begin
              work  <= {32'd0, a_abs};
              opb   <= b_abs;
              s_a   <= a_neg;
              s_b   <= b_neg;
              dz    <= 1'b0;
              count <= '0;
              state <= MUL;
              busy  <= 1'b1;
            end
            is_div: begin
              work  <= {32'd0, a_abs};
              opb   <= b_abs;
              s_a   <= a_neg;
              s_b   <= b_neg;
              dz    <= (B == 32'd0);
              count <= '0;
              state <= DIV;
              busy  <= 1'b1;
            end
            default: ;
          endcase
        end
        MUL: begin
          work  <= mul_next;
          count <= count + 5'd1;
          if (last) begin
            hi    <= prod_s[63:32];
            lo    <= prod_s[31:0];
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DIV: begin
          work  <= div_next;
          count <= count + 5'd1;
          if (last) begin
            hi    <= rem_s;
            lo    <= quo_s;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_rhl.sv
// Self-checking bench for mdu_rhl.
// Randomized and directed ops against an arithmetic reference model.
module tb_mdu_rhl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        rhl_sel;
  logic        busy;
  logic [31:0] rhl_out;

  int checks;
  int errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_rhl #(.ITER(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .A(a),
    .B(b),
    .flush(flush),
    .RHLSel(rhl_sel),
    .busy(busy),
    .RHLOut(rhl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [2:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    inout  logic [31:0] h,
    inout  logic [31:0] l
  );
    logic [63:0] p;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(x)) * longint'($signed(y)));
        h = p[63:32];
        l = p[31:0];
      end
      3'd1: begin
        p = {32'd0, x} * {32'd0, y};
        h = p[63:32];
        l = p[31:0];
      end
      3'd2: begin
        if (y == 0) begin
          l = 32'hFFFF_FFFF;
          h = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = 32'($signed(x) / $signed(y));
          h = 32'($signed(x) % $signed(y));
        end
      end
      3'd3: begin
        if (y == 0) begin
          l = 32'hFFFF_FFFF;
          h = x;
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  // issue one op and count the sampled cycles with busy high
  task automatic issue(
    input  logic [2:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          cyc
  );
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    rhl_sel = 1'b1;
    #1 h = rhl_out;
    rhl_sel = 1'b0;
    #1 l = rhl_out;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    int cyc;
    rst = 1'b0;
    #12;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h want 0/0/0", busy, h, l);
    end
    @(negedge clk);
    rst = 1'b1;
    issue(3'd4, 32'h1111_2222, 32'd0, cyc);
    issue(3'd5, 32'h3333_4444, 32'd0, cyc);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd1;
    a     = 32'd5;
    b     = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0/0/0", busy, h, l);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
      errors++;
      $display("FAIL reset_after busy=%b hi=%h lo=%h want 0/0/0", busy, h, l);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] xs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'd100, 32'h8000_0000, 32'h0000_0005};
    logic [31:0] ys  [6] = '{32'd5, 32'hFFFF_FFFF, 32'd2,
                             32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'd2, 32'd0, 32'd5};
    logic [31:0] el  [6] = '{32'hFFFF_FFF1, 32'd1, 32'hFFFF_FFFD,
                             32'd14, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] h, l;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i], cyc);
      read_hl(h, l);
      checks++;
      if (cyc !== 32 || h !== eh[i] || l !== el[i]) begin
        errors++;
        $display("FAIL directed_%0d cyc=%0d hi=%h lo=%h want 32 %h %h",
                 i, cyc, h, l, eh[i], el[i]);
      end
      model(ops[i], xs[i], ys[i], m_hi, m_lo);
    end
  endtask

  task automatic test_divz_ignored;
    logic [31:0] h, l;
    int cyc;
    @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    a     = 32'h0000_1234;
    b     = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    read_hl(h, l);
    checks++;
    if (cyc !== 32 || h !== 32'h0000_1234 || l !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divz_ignored cyc=%0d hi=%h lo=%h want 32 00001234 ffffffff",
               cyc, h, l);
    end
    m_hi = 32'h0000_1234;
    m_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_flush_mthi;
    logic [31:0] h, l;
    int cyc;
    issue(3'd4, 32'hAAAA_0000, 32'd0, cyc);
    rhl_sel = 1'b1;
    #1;
    checks++;
    if (cyc !== 0 || rhl_out !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL mthi cyc=%0d hi=%h want 0 aaaa0000", cyc, rhl_out);
    end
    issue(3'd5, 32'h0000_5555, 32'd0, cyc);
    rhl_sel = 1'b0;
    #1;
    checks++;
    if (cyc !== 0 || rhl_out !== 32'h0000_5555) begin
      errors++;
      $display("FAIL mtlo cyc=%0d lo=%h want 0 00005555", cyc, rhl_out);
    end
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'hAAAA_0000 || l !== 32'h0000_5555) begin
      errors++;
      $display("FAIL flush busy=%b hi=%h lo=%h want 0 aaaa0000 00005555",
               busy, h, l);
    end
    repeat (20) @(posedge clk);
    #1;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'hAAAA_0000 || l !== 32'h0000_5555) begin
      errors++;
      $display("FAIL flush_late busy=%b hi=%h lo=%h want 0 aaaa0000 00005555",
               busy, h, l);
    end
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h1234_5678;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    read_hl(h, l);
    checks++;
    if (busy !== 1'b0 || h !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL flush_start busy=%b hi=%h want 0 aaaa0000", busy, h);
    end
    m_hi = 32'hAAAA_0000;
    m_lo = 32'h0000_5555;
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y, h, l;
    int cyc, exp_cyc;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: x = -x;
        default: ;
      endcase
      issue(o, x, y, cyc);
      model(o, x, y, m_hi, m_lo);
      exp_cyc = (o[2] == 1'b0) ? 32 : 0;
      read_hl(h, l);
      checks++;
      if (cyc !== exp_cyc || h !== m_hi || l !== m_lo) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h want %0d %h %h",
                 i, o, x, y, cyc, h, l, exp_cyc, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    start   = 1'b0;
    op      = 3'd7;
    a       = 32'd0;
    b       = 32'd0;
    flush   = 1'b0;
    rhl_sel = 1'b0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    test_reset;
    test_directed;
    test_divz_ignored;
    test_flush_mthi;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_rhl.md
Name: mdu_rhl

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO pair.
- Sits in the EX stage beside ALU1.
- Produces RHLOut, the HI/LO read value consumed by the writeback-select and EX-forward-select muxes, for MFHI/MFLO.
- Executes MULT/MULTU/DIV/DIVU over 32 cycles, and MTHI/MTLO in one cycle.
- Drives busy, which the hazard unit uses to stall.

Parameters:
- ITER, 32, iterations per multiply/divide; fixed to operand width and not otherwise supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  issue request; sampled only when busy=0.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op.
- A  in  32  rs operand (forwarded value).
- B  in  32  rt operand (forwarded value).
- flush  in  1  abort the in-flight operation (exception/eret).
- RHLSel  in  1  read select: 0 = LO, 1 = HI.
- busy  out  1  multi-cycle operation in progress.
- RHLOut  out  32  combinational read: RHLSel ? HI : LO.

Behaviour:
- Reset (rst=0, asynchronous):
  - HI=0, LO=0, busy=0, state IDLE.
  - Counter and working registers cleared.
  - An in-flight operation is discarded.
- States: IDLE, MUL, DIV.
- IDLE with start=1 on an edge:
  - op=MTHI: HI<=A. op=MTLO: LO<=A. State stays IDLE, busy stays 0, no latency beyond that edge.
  - op=MULT/MULTU: capture operands, count<=0, go to MUL, busy<=1.
  - op=DIV/DIVU: capture operands, count<=0, go to DIV, busy<=1.
  - op=11x: ignored.
- Signed ops:
  - Capture |A| and |B|, plus sign bits sA and sB.
  - Negate results at completion: product/quotient negated if sA^sB; remainder negated if sA.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle, 32-bit partial remainder with 33-bit subtract.
- Completion:
  - On the edge where count==ITER-1: write results, state<=IDLE, busy<=0.
  - MUL writes HI=product[63:32], LO=product[31:0].
  - DIV writes LO=quotient, HI=remainder.
  - Latency: busy is high for exactly 32 cycles after the accepting edge. New HI/LO are visible on RHLOut in the first cycle busy=0.
- start while busy=1 is ignored; the hazard unit keeps the issuing instruction stalled.
- Divide by zero, signed and unsigned: LO=32'hFFFFFFFF, HI=A. Raises no exception. Still takes 32 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic.
- flush=1 on an edge:
  - Next state IDLE, busy<=0, HI/LO unchanged.
  - Takes priority over completion on the same edge.
  - start on the same edge as flush is ignored.
- HI/LO change only at completion, MTHI/MTLO, or reset.
- RHLOut has no internal bypass. A same-cycle MTHI followed by MFHI is resolved by upstream forwarding.
- All arithmetic is modulo the stated widths, with no saturation.

Test Plan:
- Reset mid-operation:
  - Stimulus: MULTU 5×7, assert rst=0 at cycle 10.
  - Required: busy=0 immediately, HI=LO=0; after release, RHLOut reads 0 for both selects.
- MULT signed:
  - Stimulus: A=0xFFFFFFFD (−3), B=5, start=1.
  - Required: busy high for exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU max:
  - Stimulus: A=B=0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001.
- DIV/DIVU:
  - Stimulus 1: DIV −7/2.
  - Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus 2: DIVU 100/7.
  - Required: LO=0x0000000E, HI=0x00000002.
  - Stimulus 3: DIV 0x80000000/0xFFFFFFFF.
  - Required: LO=0x80000000, HI=0.
- Divide by zero and ignored start:
  - Stimulus: DIVU 0x1234/0, with start re-pulsed (op=MTLO) at cycle 5 while busy.
  - Required: MTLO is ignored; after 32 cycles LO=0xFFFFFFFF, HI=0x00001234.
- flush and MTHI/MTLO:
  - Stimulus: preload via MTHI A=0xAAAA0000 and MTLO A=0x5555.
  - Required: each preload is visible one edge after issue.
  - Stimulus: start MULT 3×3, flush at cycle 20.
  - Required: busy=0 the next cycle, HI=0xAAAA0000, LO=0x5555 retained.
